mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core, and the successor of the fixed 32-bit unit. It owns the HI/LO register pair. Multiplies, including the accumulating MADD/MSUB forms, complete after a configurable latency. Division is a true iterative restoring divider producing one quotient bit per cycle. A `req` input from the exception unit suppresses state changes from instructions that are being flushed.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be even and at least 8.
- `MUL_LAT`, 5: cycles `busy` stays high after a multiply-class start; must be at least 1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; clears all state.
- `a`  in  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source).
- `b`  in  WIDTH  operand rt (divisor / multiplier).
- `op`  in  4  operation code, see Operation.
- `start`  in  1  launch the `op` presented this cycle.
- `req`  in  1  interrupt/exception flush; when high, `start` and mthi/mtlo are ignored this cycle.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  WIDTH  HI register, direct.
- `lo`  out  WIDTH  LO register, direct.
- `rdata`  out  WIDTH  `hi` when op=MFHI, `lo` when op=MFLO, else 0 (combinational).

## Operation
- Opcodes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4
  - MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - MADD=9, MADDU=10, MSUB=11, MSUBU=12
  - Codes 13–15 are treated as NONE.
- The launch condition is `start && !req && !busy`. A `start` while `busy` is high is ignored; the pipeline stalls first, so this is a protocol error with no effect.
- MTHI/MTLO write `a` into HI/LO at the next edge, require `!req && !busy`, and need no `start`. They are ignored while busy.
- Multiply class:
  - The 2·WIDTH product is computed at launch (signed for MULT/MADD/MSUB, unsigned otherwise) and held in a result register.
  - MADD/MSUB add the product to, or subtract it from, the {HI,LO} value captured at launch, modulo 2^(2·WIDTH).
  - A down-counter loads MUL_LAT. {HI,LO} is written when the counter expires.
- Divide class FSM: IDLE → DIV_ITER (WIDTH cycles, one restoring step per cycle on magnitudes) → DIV_FIX (1 cycle: sign correction and HI/LO write) → IDLE.
  - Signed rules: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend (truncating division).
- Divide by zero: LO = all ones, HI = `a`, with the full latency. The result is architecturally undefined but made deterministic.
- Signed overflow (DIV of MIN by −1): LO = MIN, HI = 0.
- Multiply FSM states are IDLE → MUL_WAIT → IDLE. Only one operation is ever in flight.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, the FSM goes to IDLE, and the counters and datapath registers are cleared. A reset during any operation aborts it, and HI/LO are 0 afterwards.
- Launch at edge E0: `busy`=1 from E0.
  - Multiply: `busy` falls and {HI,LO} updates at edge E0+MUL_LAT. The result is readable via MFHI/MFLO in the cycle after that edge.
  - Divide: same rule at edge E0+WIDTH+1. For WIDTH=32 the divide latency is 33 cycles.
- `busy` depends only on registers; it never depends combinationally on `start`.
- HI/LO hold their old values throughout an operation. An MFHI/MFLO issued while `busy` is high returns the old value; the pipeline stall prevents this.
- `req` has no effect on an operation already launched; it completes normally.
- `req` and `start` high in the same cycle: no launch, and no state change.

## Structure
- The opcode constants, FSM state encodings and the divide-by-zero policy constant belong in the shared `const.v` header alongside the existing MDUOp defines.
- One sub-module, `div_restoring`: parameter WIDTH.
  - Inputs: clk, reset, go, a_mag, b_mag.
  - Outputs: q_mag, r_mag, done.
  - Pure unsigned, WIDTH iterations.
  - Sign handling, zero and overflow detection, and the HI/LO write stay in the top module.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With MULTU on the same operands: HI=0x2, LO=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → `busy` for 33 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). With DIVU a=100, b=7: LO=14, HI=2.
- Edge cases:
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5.
- Accumulate sequence:
  - MTHI 0, then MTLO 10, then MADD a=3, b=4 → {HI,LO}=22.
  - Then MSUB a=5, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFFD (−3).
- Flush and stall behaviour:
  - `start`+MULT with `req`=1 → `busy` stays 0 and HI/LO are unchanged.
  - MTLO with `req`=1 → LO is unchanged.
  - `start` during a busy DIV → ignored; the DIV result is correct.
- Reset at cycle 10 of a DIV → the next cycle has `busy`=0, HI=0, LO=0. A new MULT 6×7 afterwards gives LO=42 after 5 cycles. Repeat the suite with WIDTH=16, MUL_LAT=1.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared opcode, FSM state and divide-by-zero policy definitions for the multiply/divide unit.
package mdu_iter_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_ITER = 2'd2,
        S_DIV_FIX  = 2'd3
    } mdu_state_e;

    // Divide by zero: LO is forced to all ones (HI receives the dividend).
    localparam bit DIVZ_LO_ONES = 1'b1;

    function automatic logic op_signed(input mdu_op_e o);
        return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/div_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH steps, done pulses with the result.
module div_restoring #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] q_mag,
    output logic [WIDTH-1:0] r_mag,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic             done_r;

    // One restoring step; the first step is folded into the go cycle.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH:0] trial;
        trial = {r, q[WIDTH-1]} - {1'b0, d};
        if (trial[WIDTH])
            return {r[WIDTH-2:0], q[WIDTH-1], q[WIDTH-2:0], 1'b0};
        else
            return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else if (go) begin
            {rem, quo} <= step('0, a_mag, b_mag);
            dvs        <= b_mag;
            cnt        <= CNT_W'(WIDTH - 1);
            done_r     <= 1'b0;
        end else if (cnt != '0) begin
            {rem, quo} <= step(rem, quo, dvs);
            cnt        <= cnt - CNT_W'(1);
            done_r     <= (cnt == CNT_W'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign q_mag = quo;
    assign r_mag = rem;
    assign done  = done_r;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO: multiplies complete after MUL_LAT cycles,
// divides after WIDTH+1 cycles through the restoring divider plus a sign-fix cycle.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_op_e                   op_e;
    mdu_state_e                state, state_n;
    logic [CNT_W-1:0]          cnt;
    logic                      is_mul, is_div, is_signed, launch, div_go, div_done;
    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [2*WIDTH-1:0]        hilo, mul_res, res_p0;
    logic [WIDTH-1:0]          a_mag, b_mag, q_mag, r_mag, a_q;
    logic                      q_neg, r_neg, divz, ovf;

    function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] q,
                                                      input logic [WIDTH-1:0] r,
                                                      input logic [WIDTH-1:0] aval,
                                                      input logic qn, input logic rn,
                                                      input logic dz, input logic ov);
        logic [WIDTH-1:0] qs, rs;
        qs = qn ? -q : q;
        rs = rn ? -r : r;
        if (dz)
            return {aval, DIVZ_LO_ONES ? {WIDTH{1'b1}} : {WIDTH{1'b0}}};
        else if (ov)
            return {{WIDTH{1'b0}}, MIN};
        else
            return {rs, qs};
    endfunction

    assign op_e   = mdu_op_e'(op);
    assign launch = start && !req && !busy;
    assign div_go = launch && is_div;
    assign hilo   = {hi, lo};

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = op_signed(op_e);
        case (op_e)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:                                         is_div = 1'b1;
            default: ;
        endcase
    end

    // Launch stage: full product (and accumulation) formed from the operands presented now.
    always_comb begin
        a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;
        case (op_e)
            OP_MADD, OP_MADDU: mul_res = hilo + prod;
            OP_MSUB, OP_MSUBU: mul_res = hilo - prod;
            default:           mul_res = prod;
        endcase
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    div_restoring #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .reset (reset),
        .go    (div_go),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .q_mag (q_mag),
        .r_mag (r_mag),
        .done  (div_done)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (launch && is_mul) state_n = S_MUL_WAIT;
                else if (div_go)      state_n = S_DIV_ITER;
            end
            S_MUL_WAIT: if (cnt == CNT_W'(1)) state_n = S_IDLE;
            S_DIV_ITER: if (div_done)         state_n = S_DIV_FIX;
            S_DIV_FIX:                        state_n = S_IDLE;
            default:                          state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != S_IDLE);
        end
    end

    // Result stage: HI/LO written on counter expiry or in the sign-fix cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            res_p0 <= '0;
            a_q    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            divz   <= 1'b0;
            ovf    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (launch && is_mul) begin
                res_p0 <= mul_res;
                cnt    <= CNT_W'(MUL_LAT);
            end else if (state == S_MUL_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (div_go) begin
                a_q   <= a;
                q_neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg <= is_signed && a[WIDTH-1];
                divz  <= (b == '0);
                ovf   <= is_signed && (a == MIN) && (b == {WIDTH{1'b1}});
            end
            if (state == S_MUL_WAIT && cnt == CNT_W'(1)) begin
                {hi, lo} <= res_p0;
            end else if (state == S_DIV_FIX) begin
                {hi, lo} <= div_result(q_mag, r_mag, a_q, q_neg, r_neg, divz, ovf);
            end else if (!busy && !req) begin
                if (op_e == OP_MTHI) hi <= a;
                if (op_e == OP_MTLO) lo <= a;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (op_e == OP_MFHI)      rdata = hi;
        else if (op_e == OP_MFLO) rdata = lo;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus randomized bench for mdu_iter at WIDTH=32/MUL_LAT=5 and WIDTH=16/MUL_LAT=1,
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset, start, req, sel;
    logic [3:0]  op;
    logic [31:0] a, b;

    logic [3:0]  op32, op16;
    logic        start32, start16, busy32, busy16;
    logic [31:0] hi32, lo32, rd32;
    logic [15:0] hi16, lo16, rd16;

    logic        obs_busy;
    logic [31:0] obs_hi, obs_lo, obs_rd;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          cur_w, cur_l;
    logic [31:0] m_hi, m_lo, msk;
    int          ops[10] = '{1, 2, 3, 4, 9, 10, 11, 12, 7, 8};

    always #5 clk = ~clk;

    assign op32    = sel ? 4'd0 : op;
    assign op16    = sel ? op : 4'd0;
    assign start32 = start && !sel;
    assign start16 = start && sel;
    assign obs_busy = sel ? busy16 : busy32;
    assign obs_hi   = sel ? {16'h0, hi16} : hi32;
    assign obs_lo   = sel ? {16'h0, lo16} : lo32;
    assign obs_rd   = sel ? {16'h0, rd16} : rd32;

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut32 (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op32), .start(start32), .req(req),
        .busy(busy32), .hi(hi32), .lo(lo32), .rdata(rd32)
    );

    mdu_iter #(.WIDTH(16), .MUL_LAT(1)) dut16 (
        .clk(clk), .reset(reset), .a(a[15:0]), .b(b[15:0]), .op(op16), .start(start16), .req(req),
        .busy(busy16), .hi(hi16), .lo(lo16), .rdata(rd16)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    function automatic longint sx(input longint v, input int w);
        longint t;
        t = v & ((longint'(1) << w) - 1);
        if (t[w-1]) t = t - (longint'(1) << w);
        return t;
    endfunction

    // New {HI,LO} (2w bits) after operation o, from plain integer arithmetic.
    function automatic logic [63:0] model(input int o, input logic [31:0] av, input logic [31:0] bv,
                                          input logic [31:0] h, input logic [31:0] l, input int w);
        longint m, sa, sb, ua, ub, q, rm;
        logic [63:0] hl, ps, pu, r, m2;
        m  = (longint'(1) << w) - 1;
        ua = longint'(av) & m;
        ub = longint'(bv) & m;
        sa = sx(ua, w);
        sb = sx(ub, w);
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        hl = ((64'(h) & 64'(m)) << w) | (64'(l) & 64'(m));
        ps = 64'(sa * sb);
        pu = 64'(ua * ub);
        q  = 0;
        rm = 0;
        case (o)
            1:  r = ps;
            2:  r = pu;
            9:  r = hl + ps;
            10: r = hl + pu;
            11: r = hl - ps;
            12: r = hl - pu;
            7:  r = (64'(ua) << w) | (hl & 64'(m));
            8:  r = (hl & ~64'(m)) | 64'(ua);
            3, 4: begin
                if (ub == 0) begin
                    q = m; rm = ua;
                end else if (o == 3 && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                    q = sa; rm = 0;
                end else if (o == 3) begin
                    q = sa / sb; rm = sa % sb;
                end else begin
                    q = ua / ub; rm = ua % ub;
                end
                r = (64'(rm & m) << w) | 64'(q & m);
            end
            default: r = hl;
        endcase
        return r & m2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (w=%0d): observed=%h expected=%h", tag, cur_w, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input int o, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] r;
        logic [31:0] eh, el;
        int lat, exp_lat;
        r  = model(o, av, bv, m_hi, m_lo, cur_w);
        el = 32'(r) & msk;
        eh = 32'(r >> cur_w) & msk;
        exp_lat = (o == 3 || o == 4) ? cur_w + 1 : cur_l;
        op = 4'(o); a = av; b = bv; start = 1'b1;
        cyc(1);
        start = 1'b0; op = 4'd0;
        chk({tag, "_busy"}, 32'(obs_busy), 32'd1);
        chk({tag, "_hold"}, obs_lo, m_lo);
        lat = 0;
        while (obs_busy && lat < 200) begin
            cyc(1);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_hi"}, obs_hi, eh);
        chk({tag, "_lo"}, obs_lo, el);
        m_hi = eh;
        m_lo = el;
        op = 4'd5; #1;
        chk({tag, "_mfhi"}, obs_rd, eh);
        op = 4'd6; #1;
        chk({tag, "_mflo"}, obs_rd, el);
        op = 4'd0;
    endtask

    task automatic mt(input string tag, input int o, input logic [31:0] av, input logic rq);
        logic [63:0] r;
        r = rq ? ((64'(m_hi) << cur_w) | 64'(m_lo)) : model(o, av, 32'd0, m_hi, m_lo, cur_w);
        op = 4'(o); a = av; req = rq;
        cyc(1);
        op = 4'd0; req = 1'b0;
        m_hi = 32'(r >> cur_w) & msk;
        m_lo = 32'(r) & msk;
        chk({tag, "_hi"}, obs_hi, m_hi);
        chk({tag, "_lo"}, obs_lo, m_lo);
    endtask

    task automatic run_suite(input logic s, input int w, input int l);
        logic [31:0] min_v;
        logic [63:0] r;
        int lat;
        sel = s; cur_w = w; cur_l = l;
        msk   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        min_v = 32'd1 << (w - 1);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_hi", obs_hi, 32'd0);
        chk("rst_lo", obs_lo, 32'd0);

        run_op("mult", 1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_lit_hi", obs_hi, msk);
        chk("mult_lit_lo", obs_lo, msk & 32'hFFFF_FFFA);
        run_op("multu", 2, 32'hFFFF_FFFE, 32'd3);
        chk("multu_lit_hi", obs_hi, 32'd2);
        run_op("div", 3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lit_lo", obs_lo, msk & 32'hFFFF_FFFD);
        chk("div_lit_hi", obs_hi, msk);
        run_op("divu", 4, 32'd100, 32'd7);
        chk("divu_lit_lo", obs_lo, 32'd14);
        chk("divu_lit_hi", obs_hi, 32'd2);
        run_op("div_ovf", 3, min_v, 32'hFFFF_FFFF);
        chk("div_ovf_lit_lo", obs_lo, min_v);
        run_op("div_zero", 4, 32'd5, 32'd0);
        chk("div_zero_lit_lo", obs_lo, msk);
        chk("div_zero_lit_hi", obs_hi, 32'd5);

        mt("mthi", 7, 32'd0, 1'b0);
        mt("mtlo", 8, 32'd10, 1'b0);
        run_op("madd", 9, 32'd3, 32'd4);
        chk("madd_lit_lo", obs_lo, 32'd22);
        run_op("msub", 11, 32'd5, 32'd5);
        chk("msub_lit_hi", obs_hi, msk);
        chk("msub_lit_lo", obs_lo, msk & 32'hFFFF_FFFD);

        op = 4'd1; a = 32'd9; b = 32'd9; start = 1'b1; req = 1'b1;
        cyc(1);
        start = 1'b0; req = 1'b0; op = 4'd0;
        chk("flush_busy", 32'(obs_busy), 32'd0);
        cyc(l + 1);
        chk("flush_hi", obs_hi, m_hi);
        chk("flush_lo", obs_lo, m_lo);
        mt("mtlo_req", 8, 32'h0000_1234, 1'b1);

        r = model(3, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, w);
        op = 4'd3; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        cyc(1);
        start = 1'b0; op = 4'd0;
        cyc(3);
        op = 4'd1; a = 32'd6; b = 32'd7; start = 1'b1;
        cyc(1);
        start = 1'b0; op = 4'd0;
        lat = 4;
        while (obs_busy && lat < 200) begin
            cyc(1);
            lat++;
        end
        m_hi = 32'(r >> w) & msk;
        m_lo = 32'(r) & msk;
        chk("stall_lat", 32'(lat), 32'(w + 1));
        chk("stall_hi", obs_hi, m_hi);
        chk("stall_lo", obs_lo, m_lo);

        op = 4'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        cyc(1);
        start = 1'b0; op = 4'd0;
        cyc(9);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_hi", obs_hi, 32'd0);
        chk("abort_lo", obs_lo, 32'd0);
        run_op("mult67", 1, 32'd6, 32'd7);
        chk("mult67_lit_lo", obs_lo, 32'd42);

        for (int i = 0; i < 24; i++) begin
            int o, k;
            logic [31:0] av, bv;
            o  = ops[$urandom_range(0, 9)];
            k  = $urandom_range(0, 7);
            av = $urandom;
            bv = $urandom;
            if (k == 0) bv = 32'd0;
            if (k == 1) begin av = min_v; bv = 32'hFFFF_FFFF; end
            if (k == 2) bv = bv & 32'h0000_000F;
            if (o == 7 || o == 8) mt("rnd_mt", o, av, 1'b0);
            else                  run_op("rnd", o, av, bv);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; sel = 1'b0;
        cur_w = 32; cur_l = 5; msk = 32'hFFFF_FFFF; m_hi = 32'd0; m_lo = 32'd0;
        run_suite(1'b0, 32, 5);
        run_suite(1'b1, 16, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
